// File: rtl/bp_cce_hybrid_pending_w_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : bp_cce_hybrid_pending_w_arbiter_pkg
// Brief  : Shared pending-bits write layout and processor config helpers.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bp_cce_hybrid_pending_w_arbiter_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int C_DEFAULT_PADDR_WIDTH = 40;

  function automatic int bp_paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: bp_paddr_width = C_DEFAULT_PADDR_WIDTH;
      default:          bp_paddr_width = C_DEFAULT_PADDR_WIDTH;
    endcase
  endfunction

  // Every requester packs its write into this layout so the slot can hold any of them.
  typedef struct packed {
    logic [C_DEFAULT_PADDR_WIDTH-1:0] addr;
    logic                             bypass_hash;
    logic                             up;
    logic                             down;
    logic                             clear;
  } bp_cce_pending_w_s;

  localparam int C_PENDING_W_WIDTH = $bits(bp_cce_pending_w_s);

endpackage

`default_nettype wire

// File: rtl/bp_cce_hybrid_pending_w_arbiter_rr.sv
//------------------------------------------------------------------------------
// Module : bp_cce_hybrid_pending_w_arbiter_rr
// Brief  : Round-robin grant select; pointer moves past the winner on a taken grant.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bp_cce_hybrid_pending_w_arbiter_rr #(
  parameter  int NUM_REQ = 3,
  localparam int TAG_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               grants_en_i,
  input  logic [NUM_REQ-1:0] reqs_i,
  output logic [NUM_REQ-1:0] grants_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               v_o
);

  logic [TAG_W-1:0] r_ptr;
  logic             w_found;
  int               w_idx;

  // Scan from the pointer, wrapping, and take the first valid requester.
  always_comb begin
    grants_o = '0;
    tag_o    = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && reqs_i[TAG_W'(w_idx)]) begin
        w_found                  = 1'b1;
        grants_o[TAG_W'(w_idx)]  = 1'b1;
        tag_o                    = TAG_W'(w_idx);
      end
    end
  end

  assign v_o = w_found;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr <= '0;
    end else if (grants_en_i && w_found) begin
      r_ptr <= (tag_o == TAG_W'(NUM_REQ - 1)) ? '0 : tag_o + TAG_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_cce_hybrid_pending_w_arbiter.sv
//------------------------------------------------------------------------------
// Module : bp_cce_hybrid_pending_w_arbiter
// Brief  : Round-robin share of the pending-bits write port through a one-entry slot.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bp_cce_hybrid_pending_w_arbiter
  import bp_cce_hybrid_pending_w_arbiter_pkg::*;
#(
  parameter  bp_params_e bp_params_p   = e_bp_default_cfg,
  parameter  int         num_req_p     = 3,
  localparam int         paddr_width_p = bp_paddr_width(bp_params_p),
  localparam int         TAG_W         = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,

  input  logic [num_req_p-1:0]               req_v_i,
  output logic [num_req_p-1:0]               req_yumi_o,
  input  logic [num_req_p*paddr_width_p-1:0] req_addr_i,
  input  logic [num_req_p-1:0]               req_addr_bypass_hash_i,
  input  logic [num_req_p-1:0]               req_up_i,
  input  logic [num_req_p-1:0]               req_down_i,
  input  logic [num_req_p-1:0]               req_clear_i,

  output logic                               pending_w_v_o,
  input  logic                               pending_w_ready_and_i,
  output logic [paddr_width_p-1:0]           pending_w_addr_o,
  output logic                               pending_w_addr_bypass_hash_o,
  output logic                               pending_up_o,
  output logic                               pending_down_o,
  output logic                               pending_clear_o,

  output logic                               empty_o
);

  bp_cce_pending_w_s        w_req [num_req_p];
  bp_cce_pending_w_s        w_sel;
  bp_cce_pending_w_s        r_slot;
  logic                     r_full;
  logic                     w_accept_en;
  logic                     w_arb_en;
  logic                     w_arb_v;
  logic                     w_grant_v;
  logic [num_req_p-1:0]     w_grants;
  logic [TAG_W-1:0]         w_tag;

  for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
    assign w_req[i] = {req_addr_i[i*paddr_width_p +: paddr_width_p],
                       req_addr_bypass_hash_i[i],
                       req_up_i[i],
                       req_down_i[i],
                       req_clear_i[i]};
  end

  // Acceptance looks only at the registered slot and the ready input, never at
  // this cycle's pending-bits handshake outcome, so yumi has no loop through it.
  assign w_accept_en = ~r_full | pending_w_ready_and_i;
  assign w_arb_en    = w_accept_en & ~reset_i;

  bp_cce_hybrid_pending_w_arbiter_rr #(
    .NUM_REQ (num_req_p)
  ) u_rr (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .grants_en_i (w_arb_en),
    .reqs_i      (req_v_i),
    .grants_o    (w_grants),
    .tag_o       (w_tag),
    .v_o         (w_arb_v)
  );

  assign w_grant_v  = w_arb_en & w_arb_v;
  assign req_yumi_o = w_grants & {num_req_p{w_grant_v}};
  assign w_sel      = w_req[w_tag];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_full <= 1'b0;
      r_slot <= '0;
    end else if (w_grant_v) begin
      r_full <= 1'b1;
      r_slot <= w_sel;
    end else if (pending_w_ready_and_i) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_grant_v) begin
      assert ($onehot({w_sel.up, w_sel.down, w_sel.clear}));
    end
  end

  assign pending_w_v_o                = r_full;
  assign pending_w_addr_o             = r_slot.addr;
  assign pending_w_addr_bypass_hash_o = r_slot.bypass_hash;
  assign pending_up_o                 = r_slot.up;
  assign pending_down_o               = r_slot.down;
  assign pending_clear_o              = r_slot.clear;

  assign empty_o = ~r_full & ~|req_v_i;

endmodule

`default_nettype wire

// File: tb/tb_bp_cce_hybrid_pending_w_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_bp_cce_hybrid_pending_w_arbiter
// Brief  : Directed self-checking bench for the pending-bits write arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bp_cce_hybrid_pending_w_arbiter;

  localparam int N  = 3;
  localparam int AW = 40;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N-1:0]    req_v_i;
  logic [N-1:0]    req_yumi_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N-1:0]    req_addr_bypass_hash_i;
  logic [N-1:0]    req_up_i;
  logic [N-1:0]    req_down_i;
  logic [N-1:0]    req_clear_i;
  logic            pending_w_v_o;
  logic            pending_w_ready_and_i;
  logic [AW-1:0]   pending_w_addr_o;
  logic            pending_w_addr_bypass_hash_o;
  logic            pending_up_o;
  logic            pending_down_o;
  logic            pending_clear_o;
  logic            empty_o;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bp_cce_hybrid_pending_w_arbiter dut (
    .clk_i                        (clk),
    .reset_i                      (reset_i),
    .req_v_i                      (req_v_i),
    .req_yumi_o                   (req_yumi_o),
    .req_addr_i                   (req_addr_i),
    .req_addr_bypass_hash_i       (req_addr_bypass_hash_i),
    .req_up_i                     (req_up_i),
    .req_down_i                   (req_down_i),
    .req_clear_i                  (req_clear_i),
    .pending_w_v_o                (pending_w_v_o),
    .pending_w_ready_and_i        (pending_w_ready_and_i),
    .pending_w_addr_o             (pending_w_addr_o),
    .pending_w_addr_bypass_hash_o (pending_w_addr_bypass_hash_o),
    .pending_up_o                 (pending_up_o),
    .pending_down_o               (pending_down_o),
    .pending_clear_o              (pending_clear_o),
    .empty_o                      (empty_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic bh,
                         input logic up, input logic dn, input logic cl);
    req_addr_i[i*AW +: AW]    = a;
    req_addr_bypass_hash_i[i] = bh;
    req_up_i[i]               = up;
    req_down_i[i]             = dn;
    req_clear_i[i]            = cl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i                = 1'b1;
    req_v_i                = '0;
    req_addr_i             = '0;
    req_addr_bypass_hash_i = '0;
    req_up_i               = '0;
    req_down_i             = '0;
    req_clear_i            = '0;
    pending_w_ready_and_i  = 1'b1;

    // Reset state, including no yumi while reset is held
    step();
    req_v_i = 3'b111;
    #1;
    chk("yumi_in_reset", 64'(req_yumi_o), 64'h0);
    step();
    req_v_i = '0;
    reset_i = 1'b0;
    #1;
    chk("rst_v", 64'(pending_w_v_o), 64'h0);
    chk("rst_addr", 64'(pending_w_addr_o), 64'h0);
    chk("rst_ops", 64'({pending_w_addr_bypass_hash_o, pending_up_o, pending_down_o, pending_clear_o}), 64'h0);
    chk("rst_empty", 64'(empty_o), 64'h1);

    // Scenario 1: single coh-ack decrement
    set_req(0, 40'h80_0000_0040, 1'b0, 1'b0, 1'b1, 1'b0);
    req_v_i = 3'b001;
    #1;
    chk("s1_yumi", 64'(req_yumi_o), 64'h1);
    chk("s1_empty_c0", 64'(empty_o), 64'h0);
    step();
    req_v_i = '0;
    #1;
    chk("s1_v", 64'(pending_w_v_o), 64'h1);
    chk("s1_addr", 64'(pending_w_addr_o), 64'h80_0000_0040);
    chk("s1_ops", 64'({pending_up_o, pending_down_o, pending_clear_o}), 64'h2);
    chk("s1_empty_c1", 64'(empty_o), 64'h0);
    step();
    chk("s1_empty_c2", 64'(empty_o), 64'h1);
    chk("s1_v_c2", 64'(pending_w_v_o), 64'h0);

    // Re-reset so the pointer starts at requester 0 again
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;

    // Scenario 2: all requesters valid, full rotation at one write per cycle
    for (int i = 0; i < N; i++) set_req(i, 40'(64'h1000 + i), 1'b0, 1'b1, 1'b0, 1'b0);
    req_v_i = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("s2_yumi", 64'(req_yumi_o), 64'(3'b001 << (c % 3)));
      step();
      chk("s2_addr", 64'({pending_w_v_o, pending_w_addr_o}), {23'd0, 1'b1, 40'(64'h1000 + (c % 3))});
    end

    // Scenario 3: backpressure with slot holding requester 2's write
    pending_w_ready_and_i = 1'b0;
    set_req(1, 40'h2001, 1'b1, 1'b0, 1'b0, 1'b1);
    set_req(2, 40'h2002, 1'b0, 1'b0, 1'b1, 1'b0);
    req_v_i = 3'b110;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("s3_yumi_bp", 64'(req_yumi_o), 64'h0);
      step();
      chk("s3_hold", 64'({pending_w_v_o, pending_w_addr_o, pending_up_o}), {22'd0, 1'b1, 40'h1002, 1'b1});
    end
    pending_w_ready_and_i = 1'b1;
    #1;
    chk("s3_yumi_drain", 64'(req_yumi_o), 64'h2);
    step();
    req_v_i = '0;
    chk("s3_addr", 64'(pending_w_addr_o), 64'h2001);
    chk("s3_ops", 64'({pending_w_v_o, pending_w_addr_bypass_hash_o, pending_up_o, pending_down_o, pending_clear_o}), 64'h19);
    step();
    chk("s3_drained", 64'(pending_w_v_o), 64'h0);

    // Scenario 4: same address from requesters 0 then 1, both issued in order
    set_req(0, 40'h100, 1'b0, 1'b1, 1'b0, 1'b0);
    set_req(1, 40'h100, 1'b0, 1'b1, 1'b0, 1'b0);
    req_v_i = 3'b001;
    #1;
    chk("s4_yumi0", 64'(req_yumi_o), 64'h1);
    step();
    req_v_i = 3'b010;
    chk("s4_w0", 64'({pending_w_v_o, pending_w_addr_o, pending_up_o}), {22'd0, 1'b1, 40'h100, 1'b1});
    #1;
    chk("s4_yumi1", 64'(req_yumi_o), 64'h2);
    step();
    req_v_i = '0;
    chk("s4_w1", 64'({pending_w_v_o, pending_w_addr_o, pending_up_o}), {22'd0, 1'b1, 40'h100, 1'b1});
    step();
    chk("s4_drained", 64'(pending_w_v_o), 64'h0);

    // Scenario 5: reset while the slot is full and stalled
    pending_w_ready_and_i = 1'b0;
    set_req(2, 40'h300, 1'b0, 1'b0, 1'b0, 1'b1);
    req_v_i = 3'b100;
    #1;
    chk("s5_fill_yumi", 64'(req_yumi_o), 64'h4);
    step();
    chk("s5_full", 64'({pending_w_v_o, pending_w_addr_o}), {23'd0, 1'b1, 40'h300});
    reset_i = 1'b1;
    req_v_i = 3'b111;
    #1;
    chk("s5_yumi_rst", 64'(req_yumi_o), 64'h0);
    step();
    chk("s5_v_after_rst", 64'(pending_w_v_o), 64'h0);
    chk("s5_yumi_rst2", 64'(req_yumi_o), 64'h0);
    reset_i = 1'b0;
    pending_w_ready_and_i = 1'b1;
    #1;
    chk("s5_first_grant", 64'(req_yumi_o), 64'h1);
    step();
    req_v_i = '0;
    chk("s5_w", 64'({pending_w_v_o, pending_w_addr_o}), {23'd0, 1'b1, 40'h100});
    step();
    chk("s5_empty", 64'(empty_o), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
